// File: rtl/div_pkg.sv
// Shared constants and FSM encoding for the sequential restoring divider.
package div_pkg;

    localparam int unsigned DEF_WIDTH = 16;
    localparam int unsigned CNT_W     = $clog2(DEF_WIDTH);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    function automatic int unsigned cnt_width(input int unsigned w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

endpackage

// File: rtl/seq_div_32_16_if.sv
// Request/response handshake bundle for seq_div_32_16.
interface seq_div_32_16_if
    import div_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH
);
    logic                   in_valid;
    logic                   in_ready;
    logic [2*WIDTH-1:0]     dividend;
    logic [WIDTH-1:0]       divisor;
    logic                   out_valid;
    logic                   out_ready;
    logic [WIDTH-1:0]       quotient;
    logic [WIDTH-1:0]       remainder;
    logic                   div_by_zero;
    logic                   overflow;

    modport master (
        output in_valid, dividend, divisor, out_ready,
        input  in_ready, out_valid, quotient, remainder, div_by_zero, overflow
    );

    modport slave (
        input  in_valid, dividend, divisor, out_ready,
        output in_ready, out_valid, quotient, remainder, div_by_zero, overflow
    );
endinterface

// File: rtl/div_step.sv
// One combinational restoring-division iteration: shift in a dividend bit, try to subtract.
module div_step #(
    parameter int unsigned WIDTH = 16
) (
    input  logic [WIDTH-1:0] rem,
    input  logic             bit_in,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_next,
    output logic             q_bit
);
    // One extra guard bit so the sign of the trial subtraction is explicit.
    logic [WIDTH+1:0] trial;

    always_comb begin
        trial = {1'b0, rem, bit_in} - {2'b00, divisor};
        q_bit = ~trial[WIDTH+1];
        rem_next = q_bit ? trial[WIDTH-1:0] : {rem[WIDTH-2:0], bit_in};
    end
endmodule

// File: rtl/seq_div_32_16.sv
// Iterative unsigned 2W/W restoring divider, one quotient bit per clock, valid/ready both sides.
module seq_div_32_16
    import div_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH
) (
    input  logic           clk,
    input  logic           rst,
    seq_div_32_16_if.slave bus
);
    localparam int unsigned CW = cnt_width(WIDTH);

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] sh_q, sh_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             dbz_q, dbz_d;
    logic             ovf_q, ovf_d;

    logic [WIDTH-1:0] step_rem;
    logic             step_q;

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem      (rem_q),
        .bit_in   (sh_q[WIDTH-1]),
        .divisor  (dvs_q),
        .rem_next (step_rem),
        .q_bit    (step_q)
    );

    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        sh_d    = sh_q;
        dvs_d   = dvs_q;
        cnt_d   = cnt_q;
        dbz_d   = dbz_q;
        ovf_d   = ovf_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.in_valid) begin
                    if (bus.divisor == '0) begin
                        state_d = ST_DONE;
                        sh_d    = '1;
                        rem_d   = bus.dividend[WIDTH-1:0];
                        dbz_d   = 1'b1;
                        ovf_d   = 1'b1;
                    end else if (bus.dividend[2*WIDTH-1:WIDTH] >= bus.divisor) begin
                        // High half already >= divisor: quotient needs more than WIDTH bits.
                        state_d = ST_DONE;
                        sh_d    = '1;
                        rem_d   = '0;
                        ovf_d   = 1'b1;
                    end else begin
                        state_d = ST_RUN;
                        rem_d   = bus.dividend[2*WIDTH-1:WIDTH];
                        sh_d    = bus.dividend[WIDTH-1:0];
                        dvs_d   = bus.divisor;
                        cnt_d   = '0;
                    end
                end
            end
            ST_RUN: begin
                rem_d = step_rem;
                sh_d  = {sh_q[WIDTH-2:0], step_q};
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(WIDTH - 1)) begin
                    state_d = ST_DONE;
                    cnt_d   = '0;
                end
            end
            ST_DONE: begin
                if (bus.out_ready) begin
                    state_d = ST_IDLE;
                    dbz_d   = 1'b0;
                    ovf_d   = 1'b0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            rem_q   <= '0;
            sh_q    <= '0;
            dvs_q   <= '0;
            cnt_q   <= '0;
            dbz_q   <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            sh_q    <= sh_d;
            dvs_q   <= dvs_d;
            cnt_q   <= cnt_d;
            dbz_q   <= dbz_d;
            ovf_q   <= ovf_d;
        end
    end

    // sh ends holding the quotient and rem the remainder; only meaningful while out_valid.
    assign bus.in_ready    = (state_q == ST_IDLE);
    assign bus.out_valid   = (state_q == ST_DONE);
    assign bus.quotient    = sh_q;
    assign bus.remainder   = rem_q;
    assign bus.div_by_zero = dbz_q;
    assign bus.overflow    = ovf_q;
endmodule
